lvds_flit_link_endpoint: RTL and testbench

//  Parametrised inter-FPGA link endpoint. It serialises local FLIT_W-bit flits into LANE_W-bit beats for the

---
 rtl/lvds_flit_link_endpoint_if.sv | 48 ++++
 rtl/lvds_flit_link_endpoint.sv | 181 ++++++++++++++++++
 tb/tb_lvds_flit_link_endpoint.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_flit_link_endpoint_if.sv
// rtl/lvds_flit_link_endpoint_if.sv - flit put/get and LVDS lane bundle for the link endpoint
//
// Purpose: groups every non-clock signal of lvds_flit_link_endpoint.
// Ports (signals):
//   loopback                        mode select, 1 = ser_* looped into des_* internally
//   tx_flit/tx_flit_en/tx_flit_rdy  local put port (FLIT_W)
//   ser_data/ser_sof/ser_valid      outgoing lane beat, ser_peer_rdy is the peer's ready
//   des_data/des_sof/des_valid      incoming lane beat, des_rdy is our ready
//   rx_flit/rx_flit_rdy/rx_flit_en  local get port, show-ahead head of the RX FIFO
//   rx_count, frame_err_cnt         RX FIFO occupancy and saturating framing-error count
// Modports: slave = the endpoint, master = the board logic / peer around it.
interface lvds_flit_link_endpoint_if #(
  parameter int FLIT_W = 32,
  parameter int LANE_W = 4,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              loopback;
  logic [FLIT_W-1:0] tx_flit;
  logic              tx_flit_en;
  logic              tx_flit_rdy;
  logic [LANE_W-1:0] ser_data;
  logic              ser_sof;
  logic              ser_valid;
  logic              ser_peer_rdy;
  logic [LANE_W-1:0] des_data;
  logic              des_sof;
  logic              des_valid;
  logic              des_rdy;
  logic [FLIT_W-1:0] rx_flit;
  logic              rx_flit_rdy;
  logic              rx_flit_en;
  logic [CW-1:0]     rx_count;
  logic [7:0]        frame_err_cnt;

  modport slave (
    input  loopback, tx_flit, tx_flit_en, ser_peer_rdy, des_data, des_sof, des_valid, rx_flit_en,
    output tx_flit_rdy, ser_data, ser_sof, ser_valid, des_rdy, rx_flit, rx_flit_rdy, rx_count,
           frame_err_cnt
  );

  modport master (
    output loopback, tx_flit, tx_flit_en, ser_peer_rdy, des_data, des_sof, des_valid, rx_flit_en,
    input  tx_flit_rdy, ser_data, ser_sof, ser_valid, des_rdy, rx_flit, rx_flit_rdy, rx_count,
           frame_err_cnt
  );
endinterface

// File: rtl/lvds_flit_link_endpoint.sv
// rtl/lvds_flit_link_endpoint.sv - inter-FPGA flit serialiser/deserialiser with RX FIFO and loopback
//
// Purpose: splits FLIT_W-bit flits into LANE_W-bit beats (LSB beat first, sof on beat 0), reassembles
//   incoming beats into flits, and buffers them in a DEPTH-deep show-ahead FIFO.
// Ports:
//   CLK  single clock
//   RST  synchronous active-high reset; drops partial TX/RX flits and all FIFO contents
//   bus  lvds_flit_link_endpoint_if.slave (put port, ser lane, des lane, get port, status)
module lvds_flit_link_endpoint #(
  parameter int FLIT_W = 32,
  parameter int LANE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  lvds_flit_link_endpoint_if.slave bus
);
  localparam int BEATS = FLIT_W / LANE_W;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // ---------------- TX serialiser ----------------
  tx_state_t         tx_state, tx_state_nx;
  logic [FLIT_W-1:0] shreg, shreg_nx;
  logic [BW-1:0]     beat, beat_nx;
  logic              tx_rdy_int;
  logic              ser_valid_int;
  logic              ser_sof_int;
  logic [LANE_W-1:0] ser_data_int;
  logic              peer_rdy_eff;

  // ---------------- RX assembler / FIFO ----------------
  logic              des_valid_eff;
  logic              des_sof_eff;
  logic [LANE_W-1:0] des_data_eff;
  logic              des_rdy_int;
  logic              beat_acc;
  logic [FLIT_W-1:0] asm_q, asm_nx;
  logic [BW-1:0]     rbeat, rbeat_nx;
  logic              frame_err;
  logic              push;
  logic              pop;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [7:0]        err_cnt;

  // In loopback the local TX lane is the only beat source and our own RX readiness throttles it.
  assign peer_rdy_eff  = bus.loopback ? des_rdy_int   : bus.ser_peer_rdy;
  assign des_valid_eff = bus.loopback ? ser_valid_int : bus.des_valid;
  assign des_sof_eff   = bus.loopback ? ser_sof_int   : bus.des_sof;
  assign des_data_eff  = bus.loopback ? ser_data_int  : bus.des_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      shreg    <= '0;
      beat     <= '0;
    end else begin
      tx_state <= tx_state_nx;
      shreg    <= shreg_nx;
      beat     <= beat_nx;
    end
  end

  always_comb begin
    tx_state_nx   = tx_state;
    shreg_nx      = shreg;
    beat_nx       = beat;
    tx_rdy_int    = 1'b0;
    ser_valid_int = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_rdy_int = 1'b1;
        if (bus.tx_flit_en) begin
          shreg_nx    = bus.tx_flit;
          beat_nx     = '0;
          tx_state_nx = TX_SEND;
        end
      end
      TX_SEND: begin
        ser_valid_int = 1'b1;
        if (peer_rdy_eff) begin
          shreg_nx = shreg >> LANE_W;
          if (beat == BW'(BEATS - 1)) begin
            // Returning to IDLE leaves one bubble cycle before the next flit can start.
            beat_nx     = '0;
            tx_state_nx = TX_IDLE;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  assign ser_data_int = (tx_state == TX_SEND) ? shreg[LANE_W-1:0] : '0;
  assign ser_sof_int  = (tx_state == TX_SEND) && (beat == '0);

  // ---------------- RX assembly ----------------
  assign des_rdy_int = (count < CW'(DEPTH));
  assign beat_acc    = des_valid_eff && des_rdy_int;

  always_comb begin
    asm_nx    = asm_q;
    rbeat_nx  = rbeat;
    frame_err = 1'b0;
    push      = 1'b0;
    if (beat_acc) begin
      if (des_sof_eff) begin
        // A new sof always wins; an unfinished flit in progress is abandoned and counted.
        frame_err            = (rbeat != '0);
        asm_nx[LANE_W-1:0]   = des_data_eff;
        rbeat_nx             = BW'(1);
      end else if (rbeat == '0) begin
        frame_err = 1'b1;
      end else begin
        for (int b = 1; b < BEATS; b++) begin
          if (rbeat == BW'(b)) asm_nx[b*LANE_W +: LANE_W] = des_data_eff;
        end
        if (rbeat == BW'(BEATS - 1)) begin
          push     = 1'b1;
          rbeat_nx = '0;
        end else begin
          rbeat_nx = rbeat + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      asm_q   <= '0;
      rbeat   <= '0;
      err_cnt <= '0;
    end else begin
      asm_q <= asm_nx;
      rbeat <= rbeat_nx;
      if (frame_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // ---------------- RX FIFO ----------------
  // push can only happen while des_rdy_int=1, so the FIFO never overflows.
  assign pop = bus.rx_flit_en && (count != '0);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= asm_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign bus.tx_flit_rdy   = tx_rdy_int;
  assign bus.ser_data      = ser_data_int;
  assign bus.ser_sof       = ser_sof_int;
  assign bus.ser_valid     = ser_valid_int && !bus.loopback;
  assign bus.des_rdy       = des_rdy_int && !bus.loopback;
  assign bus.rx_flit       = mem[rd_ptr];
  assign bus.rx_flit_rdy   = (count != '0);
  assign bus.rx_count      = count;
  assign bus.frame_err_cnt = err_cnt;
endmodule

// File: tb/tb_lvds_flit_link_endpoint.sv
// tb/tb_lvds_flit_link_endpoint.sv - self-checking bench for lvds_flit_link_endpoint
module tb_lvds_flit_link_endpoint;
  localparam int FLIT_W = 32;
  localparam int LANE_W = 4;
  localparam int DEPTH  = 4;
  localparam int BEATS  = FLIT_W / LANE_W;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  lvds_flit_link_endpoint_if #(.FLIT_W(FLIT_W), .LANE_W(LANE_W), .DEPTH(DEPTH)) bus ();

  lvds_flit_link_endpoint #(.FLIT_W(FLIT_W), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.tx_flit      = '0;
    bus.tx_flit_en   = 1'b0;
    bus.ser_peer_rdy = 1'b1;
    bus.des_data     = '0;
    bus.des_sof      = 1'b0;
    bus.des_valid    = 1'b0;
    bus.rx_flit_en   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    settle();
    chk({p, "_txrdy"}, bus.tx_flit_rdy, 1);
    chk({p, "_sval"},  bus.ser_valid, 0);
    chk({p, "_ssof"},  bus.ser_sof, 0);
    chk({p, "_sdata"}, bus.ser_data, 0);
    chk({p, "_drdy"},  bus.des_rdy, 1);
    chk({p, "_rxrdy"}, bus.rx_flit_rdy, 0);
    chk({p, "_cnt"},   bus.rx_count, 0);
    chk({p, "_err"},   bus.frame_err_cnt, 0);
  endtask

  task automatic put_flit(input logic [31:0] f);
    bus.tx_flit    = f;
    bus.tx_flit_en = 1'b1;
    tick();
    bus.tx_flit_en = 1'b0;
  endtask

  task automatic feed_flit(input logic [31:0] f);
    for (int i = 0; i < BEATS; i++) begin
      bus.des_valid = 1'b1;
      bus.des_sof   = (i == 0);
      bus.des_data  = 4'(f >> (4 * i));
      tick();
    end
    bus.des_valid = 1'b0;
    bus.des_sof   = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    bus.rx_flit_en = 1'b1;
    settle();
    chk({name, "_rdy"}, bus.rx_flit_rdy, 1);
    chk(name, bus.rx_flit, exp);
    tick();
    bus.rx_flit_en = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] d;
    logic       sof;
    logic       txr;
    logic       rxr;
  } t1_row_t;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        sof;
    logic [3:0]  d;
    logic        pop;
    logic [31:0] exp_flit;
    logic [7:0]  exp_err;
    logic [2:0]  exp_cnt;
  } t45_row_t;

  typedef struct {
    logic       sof;
    logic [3:0] d;
  } beat_t;

  t1_row_t     t1 [10];
  t45_row_t    t45 [18];
  beat_t       bq [$];
  logic [31:0] rx_exp [$];
  logic [31:0] tx_exp [$];
  logic [31:0] fl [4];

  initial begin
    t1[0] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0};
    t1[1] = '{1'b0, 4'hF, 1'b1, 1'b0, 1'b0};
    t1[2] = '{1'b0, 4'hE, 1'b0, 1'b0, 1'b0};
    t1[3] = '{1'b0, 4'hE, 1'b0, 1'b0, 1'b0};
    t1[4] = '{1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
    t1[5] = '{1'b0, 4'hD, 1'b0, 1'b0, 1'b0};
    t1[6] = '{1'b0, 4'hA, 1'b0, 1'b0, 1'b0};
    t1[7] = '{1'b0, 4'hE, 1'b0, 1'b0, 1'b0};
    t1[8] = '{1'b0, 4'hD, 1'b0, 1'b0, 1'b0};
    t1[9] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1};

    // rst valid sof data pop exp_flit exp_err exp_cnt
    t45[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0,        8'd0, 3'd0};
    t45[1]  = '{1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 32'h0,        8'd0, 3'd0};
    t45[2]  = '{1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 32'h0,        8'd0, 3'd0};
    t45[3]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 32'h0,        8'd0, 3'd0};
    t45[4]  = '{1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[5]  = '{1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[6]  = '{1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[7]  = '{1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[8]  = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[9]  = '{1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[10] = '{1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[11] = '{1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 32'h0,        8'd1, 3'd1};
    t45[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h12345678, 8'd1, 3'd0};
    t45[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0,        8'd0, 3'd0};
    t45[14] = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 32'h0,        8'd0, 3'd0};
    t45[15] = '{1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 32'h0,        8'd1, 3'd0};
    t45[16] = '{1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 32'h0,        8'd2, 3'd0};
    t45[17] = '{1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 32'h0,        8'd3, 3'd0};

    fl[0] = 32'h11112222;
    fl[1] = 32'h33334444;
    fl[2] = 32'h55556666;
    fl[3] = 32'h77778888;

    bus.loopback = 1'b0;
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk_reset("rst0");

    // ---- 1: loopback flit, cycle-exact beat table ----
    bus.loopback = 1'b1;
    bus.tx_flit  = 32'hDEADBEEF;
    for (int r = 0; r < 10; r++) begin
      bus.tx_flit_en = t1[r].en;
      settle();
      chk($sformatf("t1_data_c%0d", r),  bus.ser_data, t1[r].d);
      chk($sformatf("t1_sof_c%0d", r),   bus.ser_sof, t1[r].sof);
      chk($sformatf("t1_txrdy_c%0d", r), bus.tx_flit_rdy, t1[r].txr);
      chk($sformatf("t1_rxrdy_c%0d", r), bus.rx_flit_rdy, t1[r].rxr);
      chk($sformatf("t1_sval_c%0d", r),  bus.ser_valid, 0);
      if (r == 9) chk("t1_flit", bus.rx_flit, 32'hDEADBEEF);
      tick();
    end
    pop_check("t1_pop", 32'hDEADBEEF);
    settle();
    chk("t1_cnt_after_pop", bus.rx_count, 0);

    // ---- 2: peer back-pressure after beat 2 ----
    begin
      logic [31:0] f2;
      int i;
      int stall;
      int cyc;
      f2 = 32'h0F1E2D3C;
      bus.loopback = 1'b0;
      do_reset();
      put_flit(f2);
      i = 0;
      stall = 0;
      cyc = 0;
      while (i < BEATS && cyc < 40) begin
        bus.ser_peer_rdy = !(i == 2 && stall < 5);
        settle();
        chk("t2_valid", bus.ser_valid, 1);
        chk("t2_data",  bus.ser_data, 4'(f2 >> (4 * i)));
        chk("t2_sof",   bus.ser_sof, (i == 0));
        chk("t2_txrdy", bus.tx_flit_rdy, 0);
        if (bus.ser_peer_rdy) i++;
        else stall++;
        tick();
        cyc++;
      end
      chk("t2_beats_delivered", i, BEATS);
      bus.ser_peer_rdy = 1'b1;
      settle();
      chk("t2_txrdy_after", bus.tx_flit_rdy, 1);
      chk("t2_sval_after", bus.ser_valid, 0);
    end

    // ---- 3: FIFO full back-pressure ----
    do_reset();
    for (int k = 0; k < 4; k++) feed_flit(fl[k]);
    settle();
    chk("t3_cnt_full", bus.rx_count, 4);
    chk("t3_drdy_full", bus.des_rdy, 0);
    feed_flit(32'hFFFF0000);
    settle();
    chk("t3_cnt_ignored", bus.rx_count, 4);
    chk("t3_err_ignored", bus.frame_err_cnt, 0);
    pop_check("t3_pop0", fl[0]);
    settle();
    chk("t3_cnt_after_pop", bus.rx_count, 3);
    chk("t3_drdy_after_pop", bus.des_rdy, 1);
    for (int k = 1; k < 4; k++) pop_check($sformatf("t3_pop%0d", k), fl[k]);
    settle();
    chk("t3_cnt_drained", bus.rx_count, 0);

    // ---- 4/5: framing errors, table driven ----
    for (int r = 0; r < 18; r++) begin
      RST           = t45[r].rst;
      bus.des_valid = t45[r].valid;
      bus.des_sof   = t45[r].sof;
      bus.des_data  = t45[r].d;
      bus.rx_flit_en = t45[r].pop;
      settle();
      if (t45[r].pop) chk($sformatf("t45_flit_r%0d", r), bus.rx_flit, t45[r].exp_flit);
      tick();
      RST = 1'b0;
      chk($sformatf("t45_err_r%0d", r), bus.frame_err_cnt, t45[r].exp_err);
      chk($sformatf("t45_cnt_r%0d", r), bus.rx_count, t45[r].exp_cnt);
    end
    bus.rx_flit_en = 1'b0;
    bus.des_valid  = 1'b1;
    bus.des_sof    = 1'b0;
    for (int k = 0; k < 300; k++) tick();
    bus.des_valid = 1'b0;
    settle();
    chk("t5_err_sat", bus.frame_err_cnt, 255);
    chk("t5_cnt", bus.rx_count, 0);

    // ---- 6: reset mid-flit on TX and RX ----
    do_reset();
    bus.loopback = 1'b1;
    put_flit(32'hCAFEF00D);
    for (int k = 0; k < 10; k++) tick();
    settle();
    chk("t6_pre_cnt", bus.rx_count, 1);
    put_flit(32'h13579BDF);
    for (int k = 0; k < 3; k++) tick();
    RST = 1'b1;
    bus.loopback = 1'b0;
    tick();
    RST = 1'b0;
    chk_reset("t6_rst");
    bus.loopback = 1'b1;
    put_flit(32'h0BADC0DE);
    for (int k = 0; k < 10; k++) tick();
    settle();
    chk("t6_cnt", bus.rx_count, 1);
    chk("t6_err", bus.frame_err_cnt, 0);
    pop_check("t6_flit", 32'h0BADC0DE);

    // ---- randomized traffic against a flit-level model ----
    begin
      int exp_err;
      bit need_sof;
      int kind;
      int nb;
      logic [31:0] f;
      int rb;
      logic [31:0] col;
      int tx_left;
      int cyc;
      bus.loopback = 1'b0;
      do_reset();
      exp_err = 0;
      need_sof = 1'b0;
      for (int e = 0; e < 60; e++) begin
        kind = $urandom_range(0, 2);
        if (need_sof && kind == 2) kind = 0;
        f = $urandom;
        if (kind == 2) begin
          bq.push_back('{1'b0, 4'($urandom)});
          exp_err++;
        end else begin
          nb = (kind == 0) ? BEATS : 1 + $urandom_range(0, BEATS - 2);
          for (int i = 0; i < nb; i++) bq.push_back('{(i == 0), 4'(f >> (4 * i))});
          if (kind == 0) rx_exp.push_back(f);
          else exp_err++;
          need_sof = (kind == 1);
        end
      end
      if (need_sof) begin
        f = $urandom;
        for (int i = 0; i < BEATS; i++) bq.push_back('{(i == 0), 4'(f >> (4 * i))});
        rx_exp.push_back(f);
      end
      rb = 0;
      col = '0;
      tx_left = 20;
      cyc = 0;
      while ((bq.size() > 0 || rx_exp.size() > 0 || tx_left > 0 || tx_exp.size() > 0) && cyc < 20000) begin
        bus.des_valid = (bq.size() > 0) && ($urandom_range(0, 3) != 0);
        if (bq.size() > 0) begin
          bus.des_sof  = bq[0].sof;
          bus.des_data = bq[0].d;
        end
        bus.rx_flit_en   = ($urandom_range(0, 1) == 1);
        bus.ser_peer_rdy = ($urandom_range(0, 2) != 0);
        bus.tx_flit_en   = (tx_left > 0) && ($urandom_range(0, 1) == 1);
        bus.tx_flit      = $urandom;
        settle();
        if (bus.des_valid && bus.des_rdy) void'(bq.pop_front());
        if (bus.rx_flit_en && bus.rx_flit_rdy) begin
          if (rx_exp.size() == 0) chk("rnd_rx_extra", 1, 0);
          else chk("rnd_rx_flit", bus.rx_flit, rx_exp.pop_front());
        end
        if (bus.tx_flit_en && bus.tx_flit_rdy) begin
          tx_exp.push_back(bus.tx_flit);
          tx_left--;
        end
        if (bus.ser_valid && bus.ser_peer_rdy) begin
          chk("rnd_ser_sof", bus.ser_sof, (rb == 0));
          if (rb == 0) col = '0;
          col = col | (32'(bus.ser_data) << (4 * rb));
          rb++;
          if (rb == BEATS) begin
            rb = 0;
            if (tx_exp.size() == 0) chk("rnd_tx_extra", 1, 0);
            else chk("rnd_tx_flit", col, tx_exp.pop_front());
          end
        end
        tick();
        cyc++;
      end
      clear_inputs();
      chk("rnd_timeout", (cyc < 20000), 1);
      settle();
      chk("rnd_err", bus.frame_err_cnt, exp_err);
      chk("rnd_cnt_end", bus.rx_count, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
